button_conditioner: RTL and testbench

Two-channel push-button front end feeding the LED driver. It takes raw, asynchronous, bouncing button levels. Each channel is synchronised into the clock domain, debounced with a stable-sample counter, and turned into a single-cycle rising-edge pulse. The outputs `next_led_re` and `change_mode_re` connect directly to the LED driver's inputs of the same name. The debounced levels are also exported for status LEDs and the bench.

---
 rtl/button_conditioner.sv | 163 ++++++++++++++++
 tb/tb_button_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Two-channel button front end: 2-flop sync -> debounce FSM -> registered press pulse; press latency DEBOUNCE_CYCLES+2 edges.
// BTN_AUTO_REPEAT_EN adds hold-to-repeat pulses on the "next" channel only; no backpressure, pulses are fire-and-forget.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int RPT_WIDTH       = 25
) (
  input  logic clk,
  input  logic async_nreset,
  input  logic btn_next_raw,
  input  logic btn_mode_raw,
  output logic next_led_re,
  output logic change_mode_re,
  output logic btn_next_db,
  output logic btn_mode_db
);

`ifdef BTN_AUTO_REPEAT_EN
  localparam bit NEXT_REPEAT = 1'b1;
`else
  localparam bit NEXT_REPEAT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_WIDTH-1:0] RPT_FIRST = RPT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [RPT_WIDTH-1:0] RPT_NEXT  = RPT_WIDTH'(REPEAT_PERIOD - 1);

  logic [1:0] raw;
  logic [1:0] pulse;
  logic [1:0] level;

  assign raw            = {btn_mode_raw, btn_next_raw};
  assign next_led_re    = pulse[0];
  assign change_mode_re = pulse[1];
  assign btn_next_db    = level[0];
  assign btn_mode_db    = level[1];

  // Channel 0 is "next", channel 1 is "mode"; only "next" may repeat.
  for (genvar i = 0; i < 2; i++) begin : g_ch
    localparam bit RPT_EN = (i == 0) && NEXT_REPEAT;

    logic                 sync1;
    logic                 s;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press;
    logic                 pulse_q;
    logic [RPT_WIDTH-1:0] rpt_q, rpt_d;
    logic                 rpt_armed_q, rpt_armed_d;
    logic                 rpt_fire;

    always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
        sync1 <= 1'b0;
        s     <= 1'b0;
      end else begin
        sync1 <= raw[i];
        s     <= sync1;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press   = 1'b0;
      case (state_q)
        IDLE: begin
          if (s) begin
            state_d = PRESS_WAIT;
            cnt_d   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press   = 1'b1;
            level_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (!s) begin
            state_d = RELEASE_WAIT;
            cnt_d   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Repeat timer runs only while held; a bounce into RELEASE_WAIT freezes it rather than restarting.
    always_comb begin
      rpt_d       = rpt_q;
      rpt_armed_d = rpt_armed_q;
      rpt_fire    = 1'b0;
      if (!RPT_EN || state_q == IDLE || state_q == PRESS_WAIT) begin
        rpt_d       = '0;
        rpt_armed_d = 1'b0;
      end else if (state_q == PRESSED) begin
        if (rpt_q == (rpt_armed_q ? RPT_NEXT : RPT_FIRST)) begin
          rpt_fire    = 1'b1;
          rpt_d       = '0;
          rpt_armed_d = 1'b1;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge async_nreset) begin
      if (!async_nreset) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        level_q     <= 1'b0;
        pulse_q     <= 1'b0;
        rpt_q       <= '0;
        rpt_armed_q <= 1'b0;
      end else begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        level_q     <= level_d;
        pulse_q     <= press | rpt_fire;
        rpt_q       <= rpt_d;
        rpt_armed_q <= rpt_armed_d;
      end
    end

    assign pulse[i] = pulse_q;
    assign level[i] = level_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; edges are numbered from the first sample of a new input level.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic async_nreset;
  logic btn_next_raw;
  logic btn_mode_raw;
  logic next_led_re;
  logic change_mode_re;
  logic btn_next_db;
  logic btn_mode_db;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .RPT_WIDTH      (4)
  ) dut (
    .clk           (clk),
    .async_nreset  (async_nreset),
    .btn_next_raw  (btn_next_raw),
    .btn_mode_raw  (btn_mode_raw),
    .next_led_re   (next_led_re),
    .change_mode_re(change_mode_re),
    .btn_next_db   (btn_next_db),
    .btn_mode_db   (btn_mode_db)
  );

  always #5 clk = ~clk;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int EXP_PRESS_CNT = 2;
  localparam int EXP_REL_CNT   = 1;
  localparam int N_RPT         = 5;
  int exp_rpt[5] = '{6, 16, 21, 26, 31};
`else
  localparam int EXP_PRESS_CNT = 1;
  localparam int EXP_REL_CNT   = 0;
  localparam int N_RPT         = 1;
  int exp_rpt[5] = '{6, -1, -1, -1, -1};
`endif

  int total = 0;
  int bad   = 0;
  int edge_n;
  int nq[$];
  int mq[$];
  int next_rise, next_fall, mode_rise, mode_fall;
  logic next_db_prev, mode_db_prev;
  int bounce[5] = '{1, 0, 1, 1, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic mark();
    edge_n = -1;
    nq.delete();
    mq.delete();
    next_rise = -1;
    next_fall = -1;
    mode_rise = -1;
    mode_fall = -1;
    next_db_prev = btn_next_db;
    mode_db_prev = btn_mode_db;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    if (next_led_re)    nq.push_back(edge_n);
    if (change_mode_re) mq.push_back(edge_n);
    if (btn_next_db && !next_db_prev) next_rise = edge_n;
    if (!btn_next_db && next_db_prev) next_fall = edge_n;
    if (btn_mode_db && !mode_db_prev) mode_rise = edge_n;
    if (!btn_mode_db && mode_db_prev) mode_fall = edge_n;
    next_db_prev = btn_next_db;
    mode_db_prev = btn_mode_db;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    // Reset held with both buttons pressed
    async_nreset = 1'b0;
    btn_next_raw = 1'b0;
    btn_mode_raw = 1'b0;
    mark();
    ticks(2);
    btn_next_raw = 1'b1;
    btn_mode_raw = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_hold_outs", {next_led_re, change_mode_re, btn_next_db, btn_mode_db}, 4'b0000);
    end
    async_nreset = 1'b1;
    mark();
    ticks(12);
    check("rst_next_cnt", nq.size(), 1);
    check("rst_next_edge", q_at(nq, 0), 6);
    check("rst_mode_edge", q_at(mq, 0), 6);
    check("rst_next_db", btn_next_db, 1'b1);
    btn_next_raw = 1'b0;
    btn_mode_raw = 1'b0;
    mark();
    ticks(10);
    check("rst_rel_pulses", nq.size() + mq.size(), 0);
    check("rst_rel_next_fall", next_fall, 6);
    check("rst_rel_mode_fall", mode_fall, 6);

    // Clean press of "next" held for 20 cycles
    btn_next_raw = 1'b1;
    mark();
    ticks(20);
    check("press_next_edge", q_at(nq, 0), 6);
    check("press_next_cnt", nq.size(), EXP_PRESS_CNT);
    check("press_mode_cnt", mq.size(), 0);
    check("press_db_rise", next_rise, 6);
    btn_next_raw = 1'b0;
    mark();
    ticks(10);
    check("release_pulses", nq.size(), EXP_REL_CNT);
    check("release_db_fall", next_fall, 6);
    check("release_db_low", btn_next_db, 1'b0);

    // Bouncing "mode" input, then a steady press
    mark();
    for (int k = 0; k < 5; k++) begin
      btn_mode_raw = (bounce[k] != 0);
      tick();
    end
    check("bounce_quiet", mq.size(), 0);
    check("bounce_db_quiet", mode_rise, -1);
    btn_mode_raw = 1'b1;
    mark();
    ticks(12);
    check("bounce_mode_cnt", mq.size(), 1);
    check("bounce_mode_edge", q_at(mq, 0), 6);
    check("bounce_next_cnt", nq.size(), 0);
    btn_mode_raw = 1'b0;
    ticks(10);
    check("bounce_db_low", btn_mode_db, 1'b0);

    // Simultaneous presses
    btn_next_raw = 1'b1;
    btn_mode_raw = 1'b1;
    mark();
    ticks(8);
    check("sim_next_edge", q_at(nq, 0), 6);
    check("sim_mode_edge", q_at(mq, 0), 6);
    check("sim_total_cnt", nq.size() + mq.size(), 2);
    btn_next_raw = 1'b0;
    btn_mode_raw = 1'b0;
    ticks(10);

    // Reset during PRESS_WAIT (cnt=2), button kept high through reset
    btn_next_raw = 1'b1;
    mark();
    ticks(5);
    check("midrst_no_pulse", nq.size(), 0);
    async_nreset = 1'b0;
    ticks(2);
    check("midrst_outs", {next_led_re, btn_next_db}, 2'b00);
    async_nreset = 1'b1;
    mark();
    ticks(10);
    check("midrst_cnt", nq.size(), 1);
    check("midrst_edge", q_at(nq, 0), 6);
    btn_next_raw = 1'b0;
    ticks(10);

    // Reset landing on the pulse cycle clears outputs immediately
    btn_mode_raw = 1'b1;
    mark();
    ticks(7);
    check("pulse_before_rst", change_mode_re, 1'b1);
    async_nreset = 1'b0;
    #1;
    check("pulse_cut_by_rst", change_mode_re, 1'b0);
    check("db_cut_by_rst", btn_mode_db, 1'b0);
    btn_mode_raw = 1'b0;
    ticks(2);
    async_nreset = 1'b1;
    mark();
    ticks(10);
    check("after_rst_no_pulse", mq.size(), 0);

    // Long hold of both buttons: repeat on "next" only when enabled
    btn_next_raw = 1'b1;
    btn_mode_raw = 1'b1;
    mark();
    ticks(36);
    check("hold_next_cnt", nq.size(), N_RPT);
    for (int k = 0; k < N_RPT; k++) check("hold_next_edge", q_at(nq, k), exp_rpt[k]);
    check("hold_mode_cnt", mq.size(), 1);
    check("hold_mode_edge", q_at(mq, 0), 6);
    btn_next_raw = 1'b0;
    btn_mode_raw = 1'b0;
    ticks(12);
    check("final_db_low", {btn_next_db, btn_mode_db}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
